// File: rtl/id_decode_stage.sv
// RV32I decode stage: 32x32 register file with write-through, immediate
// generation and control decode, registered into the ID/EX bundle.
module id_decode_stage (
  input  logic        CLK,
  input  logic        reset,
  input  logic [31:0] pc_in,
  input  logic [31:0] instr_in,
  input  logic        stall,
  input  logic        flush,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        valid_out,
  output logic [31:0] pc_out,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  output logic [31:0] imm,
  output logic [4:0]  rd,
  output logic [3:0]  alu_op,
  output logic        alu_src,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        branch,
  output logic        jump,
  output logic        illegal
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic        alu_src;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        branch;
    logic        jump;
    logic        illegal;
  } idex_t;

  // sub_ok: SUB only exists for register-register ops
  function automatic logic [3:0] f3_alu(input logic [2:0] f3, input logic alt,
                                        input logic sub_ok);
    logic [3:0] op;
    op = ALU_ADD;
    case (f3)
      3'b000: op = (alt && sub_ok) ? ALU_SUB : ALU_ADD;
      3'b001: op = ALU_SLL;
      3'b010: op = ALU_SLT;
      3'b011: op = ALU_SLTU;
      3'b100: op = ALU_XOR;
      3'b101: op = alt ? ALU_SRA : ALU_SRL;
      3'b110: op = ALU_OR;
      3'b111: op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  logic [31:0] rf_q [32];
  idex_t       idex_q, idex_d, dec;

  logic [4:0]  rs1_a, rs2_a;
  logic [31:0] rs1_v, rs2_v;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [6:0]  opcode;

  assign opcode = instr_in[6:0];
  assign rs1_a  = instr_in[19:15];
  assign rs2_a  = instr_in[24:20];

  // Register file; reset wins over a same-edge write-back.
  always_ff @(posedge CLK) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (wb_en && (wb_addr != 5'd0)) begin
      rf_q[wb_addr] <= wb_data;
    end
  end

  always_comb begin
    rs1_v = rf_q[rs1_a];
    rs2_v = rf_q[rs2_a];
    if (wb_en && (wb_addr == rs1_a)) rs1_v = wb_data;
    if (wb_en && (wb_addr == rs2_a)) rs2_v = wb_data;
    if (rs1_a == 5'd0) rs1_v = '0;
    if (rs2_a == 5'd0) rs2_v = '0;
  end

  assign imm_i = {{20{instr_in[31]}}, instr_in[31:20]};
  assign imm_s = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
  assign imm_b = {{19{instr_in[31]}}, instr_in[31], instr_in[7],
                  instr_in[30:25], instr_in[11:8], 1'b0};
  assign imm_u = {instr_in[31:12], 12'b0};
  assign imm_j = {{11{instr_in[31]}}, instr_in[31], instr_in[19:12],
                  instr_in[20], instr_in[30:21], 1'b0};

  always_comb begin
    dec       = '0;
    dec.valid = 1'b1;
    dec.pc    = pc_in;
    dec.rs1   = rs1_v;
    dec.rs2   = rs2_v;
    dec.rd    = instr_in[11:7];
    case (opcode)
      OP_R: begin
        dec.reg_write = 1'b1;
        dec.alu_op    = f3_alu(instr_in[14:12], instr_in[30], 1'b1);
      end
      OP_I: begin
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.imm       = imm_i;
        dec.alu_op    = f3_alu(instr_in[14:12], instr_in[30], 1'b0);
      end
      OP_LOAD: begin
        dec.alu_src   = 1'b1;
        dec.mem_read  = 1'b1;
        dec.reg_write = 1'b1;
        dec.imm       = imm_i;
      end
      OP_STORE: begin
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
        dec.imm       = imm_s;
        dec.rd        = '0;
      end
      OP_BRANCH: begin
        dec.branch = 1'b1;
        dec.alu_op = ALU_SUB;
        dec.imm    = imm_b;
        dec.rd     = '0;
      end
      OP_JAL: begin
        dec.jump      = 1'b1;
        dec.reg_write = 1'b1;
        dec.imm       = imm_j;
      end
      OP_JALR: begin
        dec.jump      = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.imm       = imm_i;
      end
      OP_LUI: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_op    = ALU_PASSB;
        dec.imm       = imm_u;
      end
      OP_AUIPC: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.imm       = imm_u;
      end
      default: begin
        dec.illegal = 1'b1;
        dec.rd      = '0;
      end
    endcase
  end

  always_comb begin
    idex_d = dec;
    if (flush)      idex_d = '0;
    else if (stall) idex_d = idex_q;
  end

  always_ff @(posedge CLK) begin
    if (reset) idex_q <= '0;
    else       idex_q <= idex_d;
  end

  assign valid_out = idex_q.valid;
  assign pc_out    = idex_q.pc;
  assign rs1_data  = idex_q.rs1;
  assign rs2_data  = idex_q.rs2;
  assign imm       = idex_q.imm;
  assign rd        = idex_q.rd;
  assign alu_op    = idex_q.alu_op;
  assign alu_src   = idex_q.alu_src;
  assign mem_read  = idex_q.mem_read;
  assign mem_write = idex_q.mem_write;
  assign reg_write = idex_q.reg_write;
  assign branch    = idex_q.branch;
  assign jump      = idex_q.jump;
  assign illegal   = idex_q.illegal;

endmodule

// File: tb/tb_id_decode_stage.sv
// Directed plus randomized bench for id_decode_stage against a behavioural
// RV32I decode/register-file model.
module tb_id_decode_stage;

  logic        CLK = 1'b0;
  logic        reset, stall, flush, wb_en;
  logic [31:0] pc_in, instr_in, wb_data;
  logic [4:0]  wb_addr;
  logic        valid_out, alu_src, mem_read, mem_write, reg_write, branch, jump, illegal;
  logic [31:0] pc_out, rs1_data, rs2_data, imm;
  logic [4:0]  rd;
  logic [3:0]  alu_op;

  id_decode_stage dut (
    .CLK(CLK), .reset(reset), .pc_in(pc_in), .instr_in(instr_in),
    .stall(stall), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .valid_out(valid_out), .pc_out(pc_out),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .rd(rd),
    .alu_op(alu_op), .alu_src(alu_src), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .branch(branch),
    .jump(jump), .illegal(illegal)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit        valid;
    bit [31:0] pc, rs1, rs2, imm;
    bit [4:0]  rd;
    bit [3:0]  alu;
    bit        src, mrd, mwr, rwr, br, jmp, ill;
  } exp_t;

  exp_t      e;
  bit [31:0] mregs [32];
  int        total = 0, fails = 0;

  // ALU code by funct3; SUB/SRA are the +1 variant selected by instr[30]
  int f3_op [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
  bit [6:0] legal_ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};

  function automatic bit [31:0] rd_reg(bit [4:0] a, bit we, bit [4:0] wa, bit [31:0] wd);
    if (a == 0) return 0;
    if (we && wa == a) return wd;
    return mregs[a];
  endfunction

  function automatic exp_t model(bit [31:0] pc, bit [31:0] ins, bit we, bit [4:0] wa, bit [31:0] wd);
    exp_t r;
    int si, f3;
    si = ins;
    f3 = int'(ins[14:12]);
    r = '{default: 0};
    r.valid = 1;
    r.pc  = pc;
    r.rs1 = rd_reg(ins[19:15], we, wa, wd);
    r.rs2 = rd_reg(ins[24:20], we, wa, wd);
    r.rd  = ins[11:7];
    case (ins[6:0])
      7'h33: begin r.rwr = 1; r.alu = 4'(f3_op[f3] + ((ins[30] && (f3 == 0 || f3 == 5)) ? 1 : 0)); end
      7'h13: begin r.rwr = 1; r.src = 1; r.imm = si >>> 20;
                   r.alu = 4'(f3_op[f3] + ((ins[30] && f3 == 5) ? 1 : 0)); end
      7'h03: begin r.src = 1; r.mrd = 1; r.rwr = 1; r.imm = si >>> 20; end
      7'h23: begin r.src = 1; r.mwr = 1; r.rd = 0; r.imm = (si >>> 25) * 32 + int'(ins[11:7]); end
      7'h63: begin r.br = 1; r.alu = 1; r.rd = 0;
                   r.imm = (si >>> 31) * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2; end
      7'h6F: begin r.jmp = 1; r.rwr = 1;
                   r.imm = (si >>> 31) * (1 << 20) + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2; end
      7'h67: begin r.jmp = 1; r.rwr = 1; r.src = 1; r.imm = si >>> 20; end
      7'h37: begin r.rwr = 1; r.src = 1; r.alu = 10; r.imm = ins & 32'hFFFFF000; end
      7'h17: begin r.rwr = 1; r.src = 1; r.imm = ins & 32'hFFFFF000; end
      default: begin r.ill = 1; r.rd = 0; end
    endcase
    return r;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, ".valid"}, 32'(valid_out), 32'(e.valid));
    chk({tag, ".pc"},    pc_out,   e.pc);
    chk({tag, ".rs1"},   rs1_data, e.rs1);
    chk({tag, ".rs2"},   rs2_data, e.rs2);
    chk({tag, ".imm"},   imm,      e.imm);
    chk({tag, ".rd"},    32'(rd),  32'(e.rd));
    chk({tag, ".ctrl"},
        32'({alu_op, alu_src, mem_read, mem_write, reg_write, branch, jump, illegal}),
        32'({e.alu, e.src, e.mrd, e.mwr, e.rwr, e.br, e.jmp, e.ill}));
  endtask

  task automatic cyc(string tag, bit rst, bit stl, bit fl, bit [31:0] pc, bit [31:0] ins,
                     bit we, bit [4:0] wa, bit [31:0] wd);
    reset = rst; stall = stl; flush = fl; pc_in = pc; instr_in = ins;
    wb_en = we; wb_addr = wa; wb_data = wd;
    if (rst) begin
      e = '{default: 0};
      for (int i = 0; i < 32; i++) mregs[i] = 0;
    end else begin
      if (fl)        e = '{default: 0};
      else if (!stl) e = model(pc, ins, we, wa, wd);
      if (we && wa != 0) mregs[wa] = wd;
    end
    @(posedge CLK);
    #1;
    check_all(tag);
  endtask

  initial begin
    bit [31:0] ins;
    e = '{default: 0};
    // reset state
    cyc("reset", 1, 0, 0, 32'h0, 32'h0, 0, 0, 0);
    // addi x1,x0,5
    cyc("addi", 0, 0, 0, 32'h4, 32'h00500093, 0, 0, 0);
    chk("addi.imm_const", imm, 32'd5);
    // add x3,x2,x2 with write-through of x2
    cyc("add_wt", 0, 0, 0, 32'h8, 32'h002101B3, 1, 2, 32'hDEADBEEF);
    chk("add_wt.rs1_const", rs1_data, 32'hDEADBEEF);
    // sw x5,-4(x6)
    cyc("sw", 0, 0, 0, 32'hC, 32'hFE532E23, 0, 0, 0);
    chk("sw.imm_const", imm, 32'hFFFFFFFC);
    // write to x0 discarded, read of x0 stays 0
    cyc("x0_wr", 0, 0, 0, 32'h10, 32'h00000233, 1, 0, 32'h1234);
    cyc("x0_rd", 0, 0, 0, 32'h14, 32'h00000233, 0, 0, 0);
    cyc("illegal", 0, 0, 0, 32'h18, 32'hFFFFFFFF, 0, 0, 0);
    // stall holds bundle (x1 written meanwhile), then flush beats stall
    cyc("ld_addi", 0, 0, 0, 32'h1C, 32'h00108093, 0, 0, 0);
    cyc("stall0", 0, 1, 0, 32'h20, 32'h002101B3, 1, 1, 32'h55);
    cyc("stall1", 0, 1, 0, 32'h24, 32'hFE532E23, 0, 0, 0);
    cyc("stall2", 0, 1, 0, 32'h28, 32'h00000037, 0, 0, 0);
    cyc("flush_stall", 0, 1, 1, 32'h2C, 32'h00500093, 0, 0, 0);
    // reset overrides write-back; x5 reads back as 0
    cyc("wr_x5", 0, 0, 0, 32'h30, 32'h00500093, 1, 5, 32'hAAAA5555);
    cyc("rst_wb", 1, 0, 0, 32'h34, 32'h00528333, 1, 5, 32'h12345678);
    cyc("rd_x5", 0, 0, 0, 32'h38, 32'h00528333, 0, 0, 0);
    chk("rd_x5.rs1_const", rs1_data, 32'h0);

    for (int n = 0; n < 400; n++) begin
      int k;
      ins = $urandom;
      k = $urandom_range(0, 9);
      if (k < 9) ins[6:0] = legal_ops[k];
      if ($urandom_range(0, 3) == 0) ins[19:15] = 5'($urandom_range(0, 3));
      cyc("rand", ($urandom_range(0, 39) == 0), ($urandom_range(0, 4) == 0),
          ($urandom_range(0, 9) == 0), $urandom, ins, $urandom_range(0, 1),
          5'($urandom_range(0, 7)), $urandom);
    end

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

// File: doc/id_decode_stage.md
# id_decode_stage

Instruction-decode stage that consumes the fetch stage's current PC and 32-bit instruction word and produces a registered ID/EX bundle. The bundle carries register operands, the sign-extended immediate, the destination register and control signals. It contains the 32x32 architectural register file with a write-back port and write-through forwarding. It supports stall (hold) and flush (bubble) from the hazard logic. The decoded instruction set is the RV32I base subset.

## Interface
- No parameters; all widths are fixed.
- CLK  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high; sampled on the rising edge of CLK.
- pc_in  input  32  PC of the instruction currently presented by fetch.
- instr_in  input  32  instruction word from fetch.
- stall  input  1  hold the ID/EX bundle unchanged.
- flush  input  1  load a bubble into the ID/EX bundle.
- wb_en  input  1  register-file write enable.
- wb_addr  input  5  write-back destination register.
- wb_data  input  32  write-back data.
- valid_out  output  1  the bundle holds a real instruction.
- pc_out  output  32  registered pc_in.
- rs1_data, rs2_data  output  32 each  source operand values.
- imm  output  32  sign-extended immediate.
- rd  output  5  destination register.
- alu_op  output  4  ALU operation code.
- alu_src  output  1  1 selects imm as ALU operand B.
- mem_read, mem_write, reg_write, branch, jump  output  1 each  control signals.
- illegal  output  1  unsupported opcode.

## Operation
- Register file
  - 32 x 32 bits.
  - x0 always reads 0; writes to x0 are discarded.
  - A write occurs on the CLK edge when wb_en=1 and reset=0.
  - Reads are combinational from instr_in[19:15] (rs1) and instr_in[24:20] (rs2).
  - Write-through: when wb_en=1 and wb_addr equals a nonzero read address in the same cycle, the read returns wb_data.
- Decode by opcode instr_in[6:0]
  - 0110011 (R-type): reg_write=1; alu_op taken from funct3/funct7.
  - 0010011 (I-type ALU): alu_src=1, reg_write=1, I-immediate.
    - SRAI is selected by instr[30].
    - SUB is not applicable.
  - 0000011 (LOAD): alu_src=1, mem_read=1, reg_write=1, alu_op=ADD, I-immediate.
  - 0100011 (STORE): alu_src=1, mem_write=1, alu_op=ADD, S-immediate.
  - 1100011 (BRANCH): branch=1, alu_op=SUB, B-immediate.
  - 1101111 (JAL): jump=1, reg_write=1, J-immediate.
  - 1100111 (JALR): jump=1, reg_write=1, alu_src=1, alu_op=ADD, I-immediate.
  - 0110111 (LUI): reg_write=1, alu_src=1, alu_op=PASSB, U-immediate.
  - 0010111 (AUIPC): reg_write=1, alu_src=1, alu_op=ADD, U-immediate.
  - Any other opcode: illegal=1.
    - All control signals are 0 and imm=0.
    - valid_out follows the normal rules.
- alu_op encoding: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, PASSB 10.
- Immediates are fully sign-extended to 32 bits; U-type is instr[31:12] followed by 12 zero bits.
- rd is always instr_in[11:7], and is forced to 0 for STORE, BRANCH and illegal instructions.

## Timing
- Latency: the bundle for the instruction on instr_in at edge N appears on the outputs immediately after edge N.
- Priority per edge: reset > flush > stall > normal load.
- Reset
  - All outputs become 0, including valid_out, illegal and all control signals.
  - All 32 registers are cleared.
  - Reset also overrides a same-cycle write-back.
- Flush: valid_out=0, all control signals, illegal, rd and imm become 0; pc_out and operand values are don't-care (implementation zeros them).
- Stall: the entire bundle is held. The register-file write still occurs.
- Normal load: the bundle is loaded with valid_out=1.
- Flush and stall asserted together: flush wins.
- A stalled instruction whose source register is written during the stall keeps its old operand values; re-reading is the hazard unit's job.
- Reset asserted mid-stream: outputs are zero after that edge. Normal loading resumes on the first edge with reset=0.

## Test plan
- Reset for 1 cycle, then instr_in=0x00500093 (addi x1,x0,5), pc_in=0x00000004 -> next edge: valid_out=1, pc_out=0x4, rd=1, imm=5, alu_op=0, alu_src=1, reg_write=1, rs1_data=0.
- wb_en=1, wb_addr=2, wb_data=0xDEADBEEF in the same cycle as instr_in=0x002101B3 (add x3,x2,x2) -> rs1_data=rs2_data=0xDEADBEEF, rd=3, alu_op=0, alu_src=0.
- instr_in=0xFE532E23 (sw x5,-4(x6)) -> imm=0xFFFFFFFC, mem_write=1, reg_write=0, rd=0.
- Write wb_addr=0, wb_data=0x1234, then decode an instruction reading x0 -> rs1_data=0. Separately, instr_in=0xFFFFFFFF -> illegal=1, reg_write=0, valid_out=1.
- Load addi, then stall=1 for 3 cycles while changing instr_in -> outputs unchanged. Then flush=1 together with stall=1 -> valid_out=0, reg_write=0.
- Assert reset while valid_out=1 and wb_en=1 to x5 -> all outputs 0. A later read of x5 -> 0.
